// File: rtl/fft_demod_framer_mc_if.sv
// rtl/fft_demod_framer_mc_if.sv - sample/subcarrier stream bundle for fft_demod_framer_mc
//
// Purpose: one beat of a stream that has no backpressure, with sideband and a
//          symbol delimiter.
// Signals: tdata  - payload, channel 0 in the LSBs
//          tuser  - per-beat sideband
//          tlast  - last beat of a symbol
//          tvalid - beat valid
// Modports: master drives the stream, slave receives it.
interface fft_demod_framer_mc_if #(
  parameter int DW = 64,
  parameter int UW = 23
);
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  logic          tlast;
  logic          tvalid;

  modport master (output tdata, output tuser, output tlast, output tvalid);
  modport slave  (input  tdata, input  tuser, input  tlast, input  tvalid);
endinterface

// File: rtl/fft_demod_framer_mc.sv
// rtl/fft_demod_framer_mc.sv - multi-channel CP removal, FFT feed and BWP window framer
//
// Purpose: strips the cyclic prefix of each symbol, feeds FFT_LEN time-aligned
//          samples per symbol to an external FFT core, then keeps only the
//          configured subcarrier window of the FFT output and re-attaches the
//          symbol metadata through a small FIFO.
// Ports:   clk_i, reset_ni          - clock, asynchronous active-low reset
//          s_axis_in (slave)        - time samples, tuser = {meta, cp_len}
//          fft_in_tdata/tvalid      - registered samples to the FFT core
//          fft_resync_o             - one-cycle resync pulse to the FFT core
//          fft_out_tdata/blk_exp/tvalid - FFT results (shifted order)
//          cfg_bwp_start_i/len_i    - subcarrier window, sampled at bin 0
//          m_axis_out (master)      - selected subcarriers, tuser = {meta, blk_exp}
//          sym_drop_o               - one-cycle pulse on aborted symbol
//          err_o / err_clr_i        - sticky {underflow, overflow} and its clear
module fft_demod_framer_mc #(
  parameter int NUM_CH          = 2,
  parameter int IN_DW           = 32,
  parameter int OUT_DW          = 16,
  parameter int NFFT            = 8,
  parameter int CP_W            = 5,
  parameter int META_W          = 18,
  parameter int BLK_EXP_LEN     = 8,
  parameter int HALF_CP_ADVANCE = 1,
  parameter int META_DEPTH      = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  fft_demod_framer_mc_if.slave          s_axis_in,
  output logic [NUM_CH*IN_DW-1:0]       fft_in_tdata,
  output logic                          fft_in_tvalid,
  output logic                          fft_resync_o,
  input  logic [NUM_CH*IN_DW-1:0]       fft_out_tdata,
  input  logic [NUM_CH*BLK_EXP_LEN-1:0] fft_out_blk_exp,
  input  logic                          fft_out_tvalid,
  input  logic [NFFT-1:0]               cfg_bwp_start_i,
  input  logic [NFFT:0]                 cfg_bwp_len_i,
  fft_demod_framer_mc_if.master         m_axis_out,
  output logic                          sym_drop_o,
  output logic [1:0]                    err_o,
  input  logic                          err_clr_i
);

  localparam int FFT_LEN = 1 << NFFT;
  localparam int AW      = $clog2(META_DEPTH);
  localparam int TU_IN   = META_W + CP_W;
  localparam int BLK_W   = NUM_CH * BLK_EXP_LEN;
  localparam logic [NFFT-1:0] LAST_IDX = NFFT'(FFT_LEN - 1);

  typedef enum logic [1:0] {
    SKIP_CP  = 2'd0,
    PROCESS  = 2'd1,
    SKIP_END = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input side: CP removal and FFT feed
  // ---------------------------------------------------------------------------
  state_e                  state_q;
  logic                    start_q;     // next valid beat opens a symbol
  logic [CP_W-1:0]         skip_q;
  logic [CP_W-1:0]         skip_cnt_q;
  logic [NFFT-1:0]         in_cnt_q;
  logic [META_W-1:0]       meta_q;
  logic [NUM_CH*IN_DW-1:0] fft_in_tdata_q;
  logic                    fft_in_tvalid_q;
  logic                    push_q;      // meta push, one cycle after sample FFT_LEN-1
  logic                    sym_drop_q;  // also serves as FIFO flush / out_cnt reset

  logic [CP_W-1:0] cp_in;
  logic [CP_W-1:0] skip_in;
  logic [CP_W-1:0] skip_cur;
  logic [CP_W-1:0] skip_cnt_nxt;
  logic            take_start;
  logic            fwd;
  logic            last_fft;
  logic [NFFT-1:0] cur_idx;

  always_comb begin
    cp_in        = s_axis_in.tuser[CP_W-1:0];
    skip_in      = (HALF_CP_ADVANCE != 0) ? (cp_in - (cp_in >> 1)) : cp_in;
    take_start   = s_axis_in.tvalid && (state_q == SKIP_CP) && start_q;
    // A zero-length skip makes the start sample itself FFT sample 0.
    fwd          = s_axis_in.tvalid &&
                   ((state_q == PROCESS) || (take_start && (skip_in == '0)));
    cur_idx      = (state_q == PROCESS) ? in_cnt_q : '0;
    last_fft     = fwd && (cur_idx == LAST_IDX);
    skip_cur     = take_start ? skip_in : skip_q;
    skip_cnt_nxt = take_start ? CP_W'(1) : (skip_cnt_q + CP_W'(1));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q         <= SKIP_CP;
      start_q         <= 1'b1;
      skip_q          <= '0;
      skip_cnt_q      <= '0;
      in_cnt_q        <= '0;
      meta_q          <= '0;
      fft_in_tdata_q  <= '0;
      fft_in_tvalid_q <= 1'b0;
      push_q          <= 1'b0;
      sym_drop_q      <= 1'b0;
    end else begin
      fft_in_tvalid_q <= 1'b0;
      push_q          <= 1'b0;
      sym_drop_q      <= 1'b0;
      if (s_axis_in.tvalid) begin
        start_q <= s_axis_in.tlast;
        if (take_start) begin
          skip_q <= skip_in;
          meta_q <= s_axis_in.tuser[TU_IN-1 -: META_W];
        end
        if (fwd) begin
          skip_cnt_q <= '0;
          if (last_fft) begin
            fft_in_tdata_q  <= s_axis_in.tdata;
            fft_in_tvalid_q <= 1'b1;
            push_q          <= 1'b1;
            in_cnt_q        <= '0;
            state_q         <= s_axis_in.tlast ? SKIP_CP : SKIP_END;
          end else if (s_axis_in.tlast) begin
            // Short symbol: the aborting sample is not handed to the FFT core.
            sym_drop_q <= 1'b1;
            in_cnt_q   <= '0;
            state_q    <= SKIP_CP;
          end else begin
            fft_in_tdata_q  <= s_axis_in.tdata;
            fft_in_tvalid_q <= 1'b1;
            in_cnt_q        <= cur_idx + NFFT'(1);
            state_q         <= PROCESS;
          end
        end else begin
          case (state_q)
            SKIP_CP: begin
              if (s_axis_in.tlast) begin
                skip_cnt_q <= '0;              // empty symbol
              end else if (skip_cnt_nxt == skip_cur) begin
                skip_cnt_q <= '0;
                state_q    <= PROCESS;
              end else begin
                skip_cnt_q <= skip_cnt_nxt;
              end
            end
            SKIP_END: begin
              if (s_axis_in.tlast) begin
                state_q <= SKIP_CP;
              end
            end
            default: state_q <= SKIP_CP;
          endcase
        end
      end
    end
  end

  assign fft_in_tdata  = fft_in_tdata_q;
  assign fft_in_tvalid = fft_in_tvalid_q;
  assign fft_resync_o  = sym_drop_q;
  assign sym_drop_o    = sym_drop_q;

  // ---------------------------------------------------------------------------
  // Output side: metadata FIFO, window selection, truncation
  // ---------------------------------------------------------------------------
  logic [META_W-1:0]        mem_q [META_DEPTH];
  logic [AW-1:0]            wr_ptr_q;
  logic [AW-1:0]            rd_ptr_q;
  logic [AW:0]              count_q;
  logic [NFFT-1:0]          out_cnt_q;
  logic [NFFT-1:0]          bwp_start_q;
  logic [NFFT:0]            bwp_len_q;
  logic [META_W-1:0]        meta_out_q;
  logic [BLK_W-1:0]         blk_q;
  logic [1:0]               err_q;
  logic [NUM_CH*OUT_DW-1:0] m_tdata_q;
  logic [META_W+BLK_W-1:0]  m_tuser_q;
  logic                     m_tlast_q;
  logic                     m_tvalid_q;

  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     pop_req;
  logic                     pop_ok;
  logic                     push_ok;
  logic                     overflow;
  logic                     underflow;
  logic [META_W-1:0]        head;
  logic                     first_bin;
  logic [NFFT-1:0]          win_start;
  logic [NFFT:0]            win_len;
  logic [NFFT+1:0]          win_sum;
  logic [NFFT-1:0]          win_end;
  logic                     in_win;
  logic [META_W-1:0]        cur_meta;
  logic [BLK_W-1:0]         cur_blk;
  logic [NUM_CH*OUT_DW-1:0] trunc;
  logic                     unused_fft_bits;

  assign unused_fft_bits = ^fft_out_tdata;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (AW+1)'(META_DEPTH));
    first_bin  = (out_cnt_q == '0);
    pop_req    = fft_out_tvalid && first_bin;
    pop_ok     = pop_req && !fifo_empty;
    underflow  = pop_req && fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok    = push_q && (!fifo_full || pop_ok);
    overflow   = push_q && fifo_full && !pop_ok;
    head       = fifo_empty ? '0 : mem_q[rd_ptr_q];

    // Bin 0 uses the live configuration; later bins use the copy taken at bin 0.
    win_start  = first_bin ? cfg_bwp_start_i : bwp_start_q;
    win_len    = first_bin ? cfg_bwp_len_i   : bwp_len_q;
    win_sum    = {2'b00, win_start} + {1'b0, win_len} - (NFFT+2)'(1);
    win_end    = (win_sum > (NFFT+2)'(FFT_LEN - 1)) ? LAST_IDX : win_sum[NFFT-1:0];
    in_win     = (win_len != '0) && (out_cnt_q >= win_start) && (out_cnt_q <= win_end);
    cur_meta   = first_bin ? head : meta_out_q;
    cur_blk    = first_bin ? fft_out_blk_exp : blk_q;

    trunc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      trunc[c*OUT_DW +: OUT_DW] = {fft_out_tdata[c*IN_DW + IN_DW   - 1 -: OUT_DW/2],
                                   fft_out_tdata[c*IN_DW + IN_DW/2 - 1 -: OUT_DW/2]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !sym_drop_q) begin
      mem_q[wr_ptr_q] <= meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_cnt_q   <= '0;
      bwp_start_q <= '0;
      bwp_len_q   <= '0;
      meta_out_q  <= '0;
      blk_q       <= '0;
      err_q       <= 2'b00;
      m_tdata_q   <= '0;
      m_tuser_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
    end else begin
      err_q <= (err_clr_i ? 2'b00 : err_q) | {underflow, overflow};

      if (sym_drop_q) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        out_cnt_q <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
          count_q <= count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
          count_q <= count_q - (AW+1)'(1);
        end
        if (fft_out_tvalid) begin
          out_cnt_q <= out_cnt_q + NFFT'(1);
        end
      end

      if (fft_out_tvalid && first_bin) begin
        bwp_start_q <= cfg_bwp_start_i;
        bwp_len_q   <= cfg_bwp_len_i;
        meta_out_q  <= head;
        blk_q       <= fft_out_blk_exp;
      end

      m_tvalid_q <= fft_out_tvalid && in_win;
      m_tlast_q  <= fft_out_tvalid && in_win && (out_cnt_q == win_end);
      if (fft_out_tvalid && in_win) begin
        m_tdata_q <= trunc;
        m_tuser_q <= {cur_meta, cur_blk};
      end
    end
  end

  assign m_axis_out.tdata  = m_tdata_q;
  assign m_axis_out.tuser  = m_tuser_q;
  assign m_axis_out.tlast  = m_tlast_q;
  assign m_axis_out.tvalid = m_tvalid_q;
  assign err_o             = err_q;

endmodule

// File: tb/tb_fft_demod_framer_mc.sv
// tb/tb_fft_demod_framer_mc.sv - scoreboard bench for fft_demod_framer_mc
`timescale 1ns/1ps
module tb_fft_demod_framer_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_ni;
  logic [63:0] fft_out_tdata;
  logic [15:0] fft_out_blk_exp;
  logic        fft_out_tvalid;
  logic [7:0]  cfg_bwp_start;
  logic [8:0]  cfg_bwp_len;
  logic        err_clr;

  logic [63:0] fft_in_tdata_m, fft_in_tdata_0;
  logic        fft_in_tvalid_m, fft_in_tvalid_0;
  logic        resync_m, resync_0, drop_m, drop_0;
  logic [1:0]  err_m, err_0;

  fft_demod_framer_mc_if #(.DW(64), .UW(23)) s_in ();
  fft_demod_framer_mc_if #(.DW(32), .UW(34)) m_out ();
  fft_demod_framer_mc_if #(.DW(32), .UW(34)) m_out0 ();

  fft_demod_framer_mc #(.HALF_CP_ADVANCE(1)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .s_axis_in(s_in),
    .fft_in_tdata(fft_in_tdata_m), .fft_in_tvalid(fft_in_tvalid_m), .fft_resync_o(resync_m),
    .fft_out_tdata(fft_out_tdata), .fft_out_blk_exp(fft_out_blk_exp), .fft_out_tvalid(fft_out_tvalid),
    .cfg_bwp_start_i(cfg_bwp_start), .cfg_bwp_len_i(cfg_bwp_len), .m_axis_out(m_out),
    .sym_drop_o(drop_m), .err_o(err_m), .err_clr_i(err_clr)
  );

  fft_demod_framer_mc #(.HALF_CP_ADVANCE(0)) dut_h0 (
    .clk_i(clk), .reset_ni(reset_ni), .s_axis_in(s_in),
    .fft_in_tdata(fft_in_tdata_0), .fft_in_tvalid(fft_in_tvalid_0), .fft_resync_o(resync_0),
    .fft_out_tdata(fft_out_tdata), .fft_out_blk_exp(fft_out_blk_exp), .fft_out_tvalid(fft_out_tvalid),
    .cfg_bwp_start_i(cfg_bwp_start), .cfg_bwp_len_i(cfg_bwp_len), .m_axis_out(m_out0),
    .sym_drop_o(drop_0), .err_o(err_0), .err_clr_i(err_clr)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int drop_cyc_m = 0, drop_cyc_0 = 0, exp_drops_m = 0, exp_drops_0 = 0;
  bit mon_en = 1'b0;

  logic [63:0] exp_fft_m[$];
  logic [63:0] exp_fft_0[$];
  logic [66:0] exp_out[$];   // {tdata[31:0], tuser[33:0], tlast}

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] samp(input int id, input int i);
    return {16'(id * 4099), 16'(i ^ 'hA5A5), 16'(i * 7 + id), 16'(i)};
  endfunction

  // {ch1_im, ch1_re, ch0_im, ch0_re}
  function automatic logic [63:0] fo(input int k);
    return {16'(k * 257 + 'h1111), 16'(k * 3 + 'h0F0F), 16'('hFFFF - k), 16'(k * 1021)};
  endfunction

  function automatic logic [31:0] trunc8(input logic [63:0] v);
    return {v[63:56], v[47:40], v[31:24], v[15:8]};
  endfunction

  // Monitor: pops expectations whenever a DUT output beat appears.
  always @(negedge clk) begin : monitor
    logic [66:0] e;
    if (mon_en) begin
      if (fft_in_tvalid_m) begin
        if (exp_fft_m.size() == 0) chk("fft_in_m_unexpected", fft_in_tvalid_m, 1'b0);
        else chk("fft_in_m_data", fft_in_tdata_m, exp_fft_m.pop_front());
      end
      if (fft_in_tvalid_0) begin
        if (exp_fft_0.size() == 0) chk("fft_in_h0_unexpected", fft_in_tvalid_0, 1'b0);
        else chk("fft_in_h0_data", fft_in_tdata_0, exp_fft_0.pop_front());
      end
      if (drop_m || resync_m) begin
        chk("resync_eq_drop_m", resync_m, drop_m);
        if (drop_m) drop_cyc_m++;
      end
      if (drop_0 || resync_0) begin
        chk("resync_eq_drop_h0", resync_0, drop_0);
        if (drop_0) drop_cyc_0++;
      end
      if (m_out.tvalid) begin
        if (exp_out.size() == 0) begin
          chk("out_unexpected", m_out.tvalid, 1'b0);
        end else begin
          e = exp_out.pop_front();
          chk("out_tdata", m_out.tdata, e[66:35]);
          chk("out_tuser", m_out.tuser, e[34:1]);
          chk("out_tlast", m_out.tlast, e[0]);
        end
      end else if (m_out.tlast) begin
        chk("out_tlast_no_valid", m_out.tlast, 1'b0);
      end
    end
  end

  // Sends one symbol; expectations for both CP-advance variants are queued first.
  task automatic send_sym(input int cp, input int len, input logic [17:0] meta, input int id);
    int sk_m, sk_0, nf;
    sk_m = cp - (cp >> 1);
    sk_0 = cp;
    nf = (len - sk_m >= 256) ? 256 : len - sk_m - 1;
    for (int j = 0; j < nf; j++) exp_fft_m.push_back(samp(id, sk_m + j));
    if (len - sk_m < 256) exp_drops_m++;
    nf = (len - sk_0 >= 256) ? 256 : len - sk_0 - 1;
    for (int j = 0; j < nf; j++) exp_fft_0.push_back(samp(id, sk_0 + j));
    if (len - sk_0 < 256) exp_drops_0++;
    for (int i = 0; i < len; i++) begin
      s_in.tdata  = samp(id, i);
      s_in.tuser  = {meta, 5'(cp)};
      s_in.tlast  = (i == len - 1);
      s_in.tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_in.tvalid = 1'b0;
    s_in.tlast  = 1'b0;
  endtask

  // One FFT output symbol; cfg and blk_exp are scrambled after bin 0 to prove they are held.
  task automatic run_fft_out(input int start, input int len, input logic [17:0] meta, input logic [15:0] blk);
    int e_end;
    e_end = start + len - 1;
    if (e_end > 255) e_end = 255;
    for (int k = 0; k < 256; k++) begin
      cfg_bwp_start   = (k == 0) ? 8'(start) : 8'(~start);
      cfg_bwp_len     = (k == 0) ? 9'(len) : 9'd17;
      fft_out_blk_exp = (k == 0) ? blk : ~blk;
      fft_out_tdata   = fo(k);
      fft_out_tvalid  = 1'b1;
      if (len != 0 && k >= start && k <= e_end)
        exp_out.push_back({trunc8(fo(k)), meta, blk, (k == e_end)});
      @(posedge clk); #1;
    end
    fft_out_tvalid = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    reset_ni = 1'b0;
    s_in.tdata = '0; s_in.tuser = '0; s_in.tlast = 1'b0; s_in.tvalid = 1'b0;
    fft_out_tdata = '0; fft_out_blk_exp = '0; fft_out_tvalid = 1'b0;
    cfg_bwp_start = '0; cfg_bwp_len = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fft_in_tvalid", fft_in_tvalid_m, 1'b0);
    chk("rst_fft_in_tdata", fft_in_tdata_m, 64'h0);
    chk("rst_resync", resync_m, 1'b0);
    chk("rst_drop", drop_m, 1'b0);
    chk("rst_err", err_m, 2'b00);
    chk("rst_out_tvalid", m_out.tvalid, 1'b0);
    chk("rst_out_tdata", m_out.tdata, 32'h0);
    chk("rst_out_tuser", m_out.tuser, 34'h0);
    chk("rst_out_tlast", m_out.tlast, 1'b0);
    reset_ni = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    send_sym(18, 274, 18'h00A01, 1);
    send_sym(20, 276, 18'h00A02, 2);
    send_sym(0, 256, 18'h00A03, 3);
    send_sym(18, 110, 18'h00A04, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_drop_cycles_m", drop_cyc_m, 1);
    chk("abort_drop_cycles_h0", drop_cyc_0, 1);
    send_sym(18, 274, 18'h155AA, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("err_after_input", err_m, 2'b00);

    run_fft_out(8, 240, 18'h155AA, 16'h0503);
    repeat (2) @(posedge clk);
    #1;
    chk("err_after_win", err_m, 2'b00);

    run_fft_out(200, 100, 18'h0, 16'h0A0B);
    repeat (2) @(posedge clk);
    #1;
    chk("err_underflow", err_m, 2'b10);
    clear_err();
    chk("err_cleared_1", err_m, 2'b00);

    run_fft_out(5, 0, 18'h0, 16'h0C0D);
    repeat (2) @(posedge clk);
    #1;
    chk("err_underflow_len0", err_m, 2'b10);
    clear_err();
    chk("err_cleared_2", err_m, 2'b00);

    for (int n = 0; n < 17; n++) send_sym(0, 256, 18'h20000 + 18'(n), 10 + n);
    repeat (3) @(posedge clk);
    #1;
    chk("err_overflow", err_m, 2'b01);
    run_fft_out(0, 4, 18'h20000, 16'h1122);
    repeat (3) @(posedge clk);
    #1;
    chk("err_after_full_pop", err_m, 2'b01);

    mon_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      s_in.tdata = samp(50, i); s_in.tuser = {18'h3, 5'd0}; s_in.tlast = 1'b0; s_in.tvalid = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_reset_fft_in_tvalid", fft_in_tvalid_m, 1'b1);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("async_rst_fft_in_tvalid", fft_in_tvalid_m, 1'b0);
    chk("async_rst_fft_in_tdata", fft_in_tdata_m, 64'h0);
    chk("async_rst_err", err_m, 2'b00);
    chk("async_rst_out_tvalid", m_out.tvalid, 1'b0);
    chk("async_rst_out_tdata", m_out.tdata, 32'h0);
    chk("async_rst_out_tuser", m_out.tuser, 34'h0);
    chk("async_rst_drop", drop_m, 1'b0);
    chk("async_rst_resync", resync_m, 1'b0);
    s_in.tvalid = 1'b0;
    @(posedge clk); #1;
    reset_ni = 1'b1;
    exp_fft_m.delete();
    exp_fft_0.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    send_sym(18, 274, 18'h0BEEF, 40);
    repeat (5) @(posedge clk);
    #1;

    chk("left_fft_in_m", exp_fft_m.size(), 0);
    chk("left_fft_in_h0", exp_fft_0.size(), 0);
    chk("left_out", exp_out.size(), 0);
    chk("drop_cycles_m", drop_cyc_m, exp_drops_m);
    chk("drop_cycles_h0", drop_cyc_0, exp_drops_0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_demod_framer_mc.md
Name: fft_demod_framer_mc

Overview:
Multi-channel successor to the single-antenna FFT demodulator front/back end. It removes the cyclic prefix per symbol using a runtime CP length, with optional half-CP advance, and streams NUM_CH time-aligned channels into an external shared-timing FFT core. On the FFT output it selects a runtime-configurable BWP subcarrier window and re-attaches per-symbol metadata through an internal FIFO. It sits between the time-domain receiver (after PSS/CFO) and the channel estimator / PBCH / PDCCH chain.

Parameters:
NUM_CH, 2, number of antenna channels processed in lockstep
IN_DW, 32, per-channel complex input width ({im,re}, IN_DW/2 each)
OUT_DW, 16, per-channel complex output width ({im,re})
NFFT, 8, log2 FFT length; FFT_LEN = 2**NFFT
CP_W, 5, width of CP length field in input tuser
META_W, 18, width of symbol metadata (sfn, subframe, symbol)
BLK_EXP_LEN, 8, per-channel block exponent width from FFT core
HALF_CP_ADVANCE, 1, 1: FFT window starts cp_len>>1 samples early
META_DEPTH, 16, metadata FIFO depth (power of 2)

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
s_axis_in_tdata  in  NUM_CH*IN_DW  time samples, ch0 in LSBs
s_axis_in_tuser  in  META_W+CP_W  {meta, cp_len}
s_axis_in_tlast  in  1  last sample of symbol (CP+body)
s_axis_in_tvalid  in  1  sample valid (no backpressure)
fft_in_tdata  out  NUM_CH*IN_DW  samples to FFT core
fft_in_tvalid  out  1  FFT input enable
fft_resync_o  out  1  one-cycle reset pulse to FFT core
fft_out_tdata  in  NUM_CH*IN_DW  FFT results, shifted order (DC at FFT_LEN/2)
fft_out_blk_exp  in  NUM_CH*BLK_EXP_LEN  block exponents, constant per symbol
fft_out_tvalid  in  1  FFT output valid, all channels aligned
cfg_bwp_start_i  in  NFFT  first output subcarrier index
cfg_bwp_len_i  in  NFFT+1  number of output subcarriers (0 = none)
m_axis_out_tdata  out  NUM_CH*OUT_DW  selected subcarriers
m_axis_out_tuser  out  META_W+NUM_CH*BLK_EXP_LEN  {meta, blk_exp chN-1..ch0}
m_axis_out_tlast  out  1  last selected subcarrier of symbol
m_axis_out_tvalid  out  1  output valid
sym_drop_o  out  1  one-cycle pulse: symbol aborted (early tlast)
err_o  out  2  sticky: [0] meta FIFO overflow, [1] meta FIFO underflow
err_clr_i  in  1  clears err_o

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM=SKIP_CP; counters 0; FIFO empty; cp_len=0.
- Symbol start = first valid sample after reset or after a valid tlast. At that sample cp_len latches from tuser[CP_W-1:0], meta from tuser[MSBs].
- skip = cp_len - (HALF_CP_ADVANCE ? cp_len>>1 : 0).
- SKIP_CP: drop skip samples, including the start sample. If skip==0, the start sample is FFT sample 0 (state goes directly to PROCESS).
- PROCESS: forward FFT_LEN samples. fft_in_* is registered, latency 1 cycle from the s_axis beat. Meta is pushed on acceptance of sample FFT_LEN-1.
  - If tlast coincides with sample FFT_LEN-1: go to SKIP_CP.
  - Else: go to SKIP_END.
  - tlast on any earlier PROCESS sample: abort. sym_drop_o and fft_resync_o pulse 1 cycle later; output counter reset; FIFO flushed; next symbol start is the following valid sample.
- SKIP_END: drop samples until tlast, then SKIP_CP.
- tlast during SKIP_CP: treated as an empty symbol; no push, no drop pulse.
- Output side:
  - out_cnt counts fft_out_tvalid beats 0..FFT_LEN-1 and wraps.
  - At out_cnt==0: latch cfg_bwp_start/len; pop the FIFO.
  - If the FIFO is empty at pop: meta field=0 and err_o[1] set.
- Push when FIFO full: drop the entry, set err_o[0]. Simultaneous push and pop on a full FIFO is legal (no overflow).
- Window: end = min(start+len-1, FFT_LEN-1). m_axis_out_tvalid = fft_out_tvalid && start<=out_cnt<=end && len!=0.
- m_axis_out_tlast on out_cnt==end.
- m_axis_out_tdata per channel = {im[IN_DW/2-1 -: OUT_DW/2], re[IN_DW/2-1 -: OUT_DW/2]} (truncate, no rounding).
- Output latency: 1 registered cycle from fft_out beat.
- tuser blk_exp is sampled at out_cnt==0 and held for the symbol.
- err_clr_i clears err_o next cycle; a simultaneous new error wins.

Test Plan:
1. NUM_CH=2, NFFT=8, HALF=1, cp_len=18, 274-sample symbol with tlast on last -> fft_in_tvalid for input indices 9..264 (256 beats), both channels match inputs delayed 1 cycle; one FIFO push at index 264.
2. HALF=0, cp_len=20, 276-sample symbol, then cp_len=0 symbol of 256 -> first forwards indices 20..275; second forwards its start sample as FFT sample 0.
3. tlast at PROCESS sample 100 -> sym_drop_o and fft_resync_o high exactly 1 cycle, FIFO empty; next 274-sample symbol processes normally.
4. bwp start=8, len=240, 256 fft_out beats, meta=0x155AA -> 240 output beats at out_cnt 8..247, tlast at 247, tuser meta=0x155AA with blk_exp as applied.
5. start=200, len=100 -> 56 beats (200..255), tlast at 255. len=0 -> no output beats.
6. 17 pushes with no pops (depth 16) -> err_o=2'b01. Pop on empty -> err_o[1]=1, meta=0. Assert reset_ni mid-symbol -> all outputs 0 asynchronously.
